// File: rtl/tx_packet_framer.sv
// tx_packet_framer
// Wraps a 16-bit valid/ready word stream into fixed-length packets
// (header, length, payload, check word) and writes them into the FT600
// TX FIFO through its tx_en/tx_data/tx_full write interface.
//
// Build option: define FRAMER_CRC16_EN to make the check word a
// CRC-16/CCITT-FALSE of the payload. Without it, the check word is the
// 16-bit modular sum of the payload words.
module tx_packet_framer #(
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter logic [7:0]  SYNC        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        tx_en,
    output logic [15:0] tx_data,
    input  logic        tx_full,
    output logic        busy,
    output logic [15:0] pkt_count,
    output logic [7:0]  seq
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    localparam logic [15:0] LEN_WORD = 16'(PAYLOAD_LEN);
    localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);

`ifdef FRAMER_CRC16_EN
    localparam logic [15:0] CHECK_INIT = 16'hFFFF;

    // CRC-16/CCITT-FALSE step over one whole word, MSB first. Shifting the
    // 16 bits in order is the same as feeding the high byte then the low byte.
    function automatic logic [15:0] check_next(input logic [15:0] acc,
                                               input logic [15:0] word);
        logic [15:0] crc;
        crc = acc;
        for (int i = 15; i >= 0; i--) begin
            if (crc[15] ^ word[i]) begin
                crc = {crc[14:0], 1'b0} ^ 16'h1021;
            end else begin
                crc = {crc[14:0], 1'b0};
            end
        end
        return crc;
    endfunction
`else
    localparam logic [15:0] CHECK_INIT = 16'h0000;

    // Modular sum; the carry out of bit 15 is dropped.
    function automatic logic [15:0] check_next(input logic [15:0] acc,
                                               input logic [15:0] word);
        return acc + word;
    endfunction
`endif

    state_t      state;
    state_t      state_next;
    logic [15:0] checksum;
    logic [15:0] word_cnt;

    // State register.
    // NOTE: every clocked assignment uses <= so all registers sample the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Per-packet bookkeeping, advanced only on an actual FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq       <= 8'd0;
            pkt_count <= 16'd0;
            checksum  <= 16'd0;
            word_cnt  <= 16'd0;
        end else if (tx_en) begin
            case (state)
                LEN: begin
                    word_cnt <= 16'd0;
                    checksum <= CHECK_INIT;
                end
                PAYLOAD: begin
                    word_cnt <= word_cnt + 16'd1;
                    checksum <= check_next(checksum, src_data);
                end
                CSUM: begin
                    seq       <= seq + 8'd1;
                    pkt_count <= pkt_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and combinational write/handshake outputs.
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        tx_en      = 1'b0;
        tx_data    = 16'h0000;
        src_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                tx_data = {SYNC, seq};
                tx_en   = ~tx_full;
                if (!tx_full) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                tx_data = LEN_WORD;
                tx_en   = ~tx_full;
                if (!tx_full) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                src_ready = ~tx_full;
                tx_en     = src_valid & ~tx_full;
                tx_data   = src_data;
                if (src_valid && !tx_full && word_cnt == LAST_IDX) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                tx_data = checksum;
                tx_en   = ~tx_full;
                if (!tx_full) begin
                    // enable is only looked at here and in IDLE, so dropping
                    // it mid-packet never truncates a packet.
                    state_next = enable ? HDR : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb_tx_packet_framer
// Two framer instances: dut_a with PAYLOAD_LEN=4 for framing, stalls, gaps,
// enable drop and reset; dut_b with PAYLOAD_LEN=1 for sequence wrap-around.
// Expected FIFO words are queued when a packet is scheduled and popped by a
// negedge monitor whenever the DUT writes.
`timescale 1ns/1ps
module tb_tx_packet_framer;

    localparam int LEN_A  = 4;
    localparam int LEN_B  = 1;
    localparam int BUDGET = 200;

`ifdef FRAMER_CRC16_EN
    localparam logic [15:0] INIT = 16'hFFFF;

    // Byte-wise CRC-16/CCITT-FALSE: high byte first, then low byte.
    function automatic logic [15:0] fold(input logic [15:0] acc, input logic [15:0] w);
        logic [15:0] c;
        logic [7:0]  b;
        c = acc;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? w[15:8] : w[7:0];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction
`else
    localparam logic [15:0] INIT = 16'h0000;

    function automatic logic [15:0] fold(input logic [15:0] acc, input logic [15:0] w);
        return 16'(acc + w);
    endfunction
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, enable_a, src_valid_a, src_ready_a, tx_en_a, tx_full_a, busy_a;
    logic [15:0] src_data_a, tx_data_a, pkt_count_a;
    logic [7:0]  seq_a;

    logic        rst_b, enable_b, src_valid_b, src_ready_b, tx_en_b, tx_full_b, busy_b;
    logic [15:0] src_data_b, tx_data_b, pkt_count_b;
    logic [7:0]  seq_b;

    tx_packet_framer #(.PAYLOAD_LEN(LEN_A), .SYNC(8'hA5)) dut_a (
        .clk(clk), .rst(rst_a), .enable(enable_a),
        .src_valid(src_valid_a), .src_data(src_data_a), .src_ready(src_ready_a),
        .tx_en(tx_en_a), .tx_data(tx_data_a), .tx_full(tx_full_a),
        .busy(busy_a), .pkt_count(pkt_count_a), .seq(seq_a)
    );

    tx_packet_framer #(.PAYLOAD_LEN(LEN_B), .SYNC(8'hA5)) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b),
        .src_valid(src_valid_b), .src_data(src_data_b), .src_ready(src_ready_b),
        .tx_en(tx_en_b), .tx_data(tx_data_b), .tx_full(tx_full_b),
        .busy(busy_b), .pkt_count(pkt_count_b), .seq(seq_b)
    );

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          cyc_g     = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    logic [15:0] e_a, e_b;
    int          writes_a, first_wr_a, last_wr_a;
    int          writes_b, first_wr_b, last_wr_b;
    logic [7:0]  seq_m;
    logic [15:0] pkt_m;

    always @(posedge clk) cyc_g++;

    // Scoreboard for dut_a: every write must match the head of the queue,
    // and no write may happen while the FIFO reports full.
    always @(negedge clk) begin
        if (!rst_a) begin
            if (tx_full_a === 1'b1) begin
                check_cnt++;
                if (tx_en_a !== 1'b0)
                    $display("FAIL a_tx_en_while_full actual=%b required=0", tx_en_a);
                else
                    pass_cnt++;
            end
            if (tx_en_a === 1'b1) begin
                check_cnt++;
                if (writes_a == 0) first_wr_a = cyc_g;
                last_wr_a = cyc_g;
                writes_a++;
                if (exp_a.size() == 0) begin
                    $display("FAIL a_unexpected_write actual=%h required=none", tx_data_a);
                end else begin
                    e_a = exp_a.pop_front();
                    if (tx_data_a !== e_a)
                        $display("FAIL a_tx_data actual=%h required=%h", tx_data_a, e_a);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    // Scoreboard for dut_b.
    always @(negedge clk) begin
        if (!rst_b && tx_en_b === 1'b1) begin
            check_cnt++;
            if (writes_b == 0) first_wr_b = cyc_g;
            last_wr_b = cyc_g;
            writes_b++;
            if (exp_b.size() == 0) begin
                $display("FAIL b_unexpected_write actual=%h required=none", tx_data_b);
            end else begin
                e_b = exp_b.pop_front();
                if (tx_data_b !== e_b)
                    $display("FAIL b_tx_data actual=%h required=%h", tx_data_b, e_b);
                else
                    pass_cnt++;
            end
        end
    end

    // Queue one PAYLOAD_LEN=4 packet whose payload is first, first+1, ...
    task automatic push_packet_a(input logic [15:0] first);
        logic [15:0] acc;
        acc = INIT;
        exp_a.push_back({8'hA5, seq_m});
        exp_a.push_back(16'(LEN_A));
        for (int i = 0; i < LEN_A; i++) begin
            exp_a.push_back(16'(first + i));
            acc = fold(acc, 16'(first + i));
        end
        exp_a.push_back(acc);
        seq_m = seq_m + 8'd1;
        pkt_m = pkt_m + 16'd1;
    endtask

    // Drive dut_a with n_pkts packets of consecutive words from base.
    // stall: tx_full on cycles 2-4 (LEN) and 7-9 (second payload word).
    // gap: src_valid high only on every third cycle.
    // enable stays high for cycles < drop_cyc.
    task automatic run_stream_a(input int n_pkts, input bit stall, input bit gap,
                                input int drop_cyc, input logic [15:0] base);
        int  idx, cyc;
        bit  accepted, done;
        idx  = 0;
        done = 1'b0;
        for (int p = 0; p < n_pkts; p++) push_packet_a(16'(base + p * LEN_A));
        for (cyc = 0; cyc < BUDGET && !done; cyc++) begin
            enable_a    = (cyc < drop_cyc);
            tx_full_a   = stall && ((cyc >= 2 && cyc <= 4) || (cyc >= 7 && cyc <= 9));
            src_valid_a = (idx < n_pkts * LEN_A) && (!gap || (cyc % 3 == 0));
            src_data_a  = 16'(base + idx);
            @(negedge clk);
            if (tx_full_a) begin
                check_cnt++;
                if (src_ready_a !== 1'b0)
                    $display("FAIL src_ready_while_full actual=%b required=0", src_ready_a);
                else
                    pass_cnt++;
            end
            if (gap && src_ready_a === 1'b1) begin
                check_cnt++;
                if (tx_en_a !== src_valid_a)
                    $display("FAIL gap_tx_en actual=%b required=%b", tx_en_a, src_valid_a);
                else
                    pass_cnt++;
            end
            accepted = src_valid_a && src_ready_a;
            done     = (exp_a.size() == 0) && (busy_a === 1'b0);
            @(posedge clk);
            #1;
            if (accepted) idx++;
        end
        enable_a    = 1'b0;
        src_valid_a = 1'b0;
        tx_full_a   = 1'b0;
        check_cnt++;
        if (!done)
            $display("FAIL stream_a_timeout actual=%0d_pending required=0", exp_a.size());
        else
            pass_cnt++;
        check_cnt++;
        if (pkt_count_a !== pkt_m || seq_a !== seq_m)
            $display("FAIL a_counters actual=%0d/%0d required=%0d/%0d",
                     pkt_count_a, seq_a, pkt_m, seq_m);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; enable_a = 1'b0; src_valid_a = 1'b0; src_data_a = 16'h0; tx_full_a = 1'b0;
        rst_b = 1'b1; enable_b = 1'b0; src_valid_b = 1'b0; src_data_b = 16'h0; tx_full_b = 1'b0;
        seq_m = 8'd0; pkt_m = 16'd0;
        writes_a = 0; writes_b = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({busy_a, tx_en_a, src_ready_a} !== 3'b000)
            $display("FAIL reset_ctrl actual=%b required=000", {busy_a, tx_en_a, src_ready_a});
        else
            pass_cnt++;
        check_cnt++;
        if (tx_data_a !== 16'h0000)
            $display("FAIL reset_tx_data actual=%h required=0000", tx_data_a);
        else
            pass_cnt++;
        check_cnt++;
        if (seq_a !== 8'd0 || pkt_count_a !== 16'd0)
            $display("FAIL reset_counters actual=%0d/%0d required=0/0", seq_a, pkt_count_a);
        else
            pass_cnt++;
        check_cnt++;
        if (busy_b !== 1'b0 || pkt_count_b !== 16'd0)
            $display("FAIL reset_b actual=%b/%0d required=0/0", busy_b, pkt_count_b);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Two back-to-back packets: 14 writes on consecutive cycles.
    task automatic test_basic();
        writes_a = 0;
        run_stream_a(2, 1'b0, 1'b0, 9, 16'h0001);
        check_cnt++;
        if (writes_a != 14 || last_wr_a - first_wr_a != 13)
            $display("FAIL basic_throughput actual=%0d_writes_span_%0d required=14_span_13",
                     writes_a, last_wr_a - first_wr_a);
        else
            pass_cnt++;
    endtask

    task automatic test_backpressure();
        run_stream_a(1, 1'b1, 1'b0, 2, 16'h0001);
    endtask

    task automatic test_gaps();
        run_stream_a(1, 1'b0, 1'b1, 2, 16'h1230);
    endtask

    // enable drops right after the header write; packet still completes.
    task automatic test_enable_drop();
        writes_a = 0;
        run_stream_a(1, 1'b0, 1'b0, 2, 16'hFFFE);
        check_cnt++;
        if (writes_a != 7 || busy_a !== 1'b0)
            $display("FAIL enable_drop actual=%0d_writes_busy_%b required=7_writes_busy_0",
                     writes_a, busy_a);
        else
            pass_cnt++;
    endtask

    // Reset while payload word 2 is on the bus abandons the packet.
    task automatic test_reset_mid();
        exp_a.push_back({8'hA5, seq_m});
        exp_a.push_back(16'(LEN_A));
        exp_a.push_back(16'h0100);
        exp_a.push_back(16'h0101);
        enable_a = 1'b1; tx_full_a = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            src_valid_a = (cyc >= 3);
            src_data_a  = 16'(16'h0100 + (cyc >= 3 ? cyc - 3 : 0));
            @(posedge clk);
            #1;
        end
        src_valid_a = 1'b1;
        src_data_a  = 16'h0102;
        rst_a       = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0; enable_a = 1'b0; src_valid_a = 1'b0;
        seq_m = 8'd0; pkt_m = 16'd0;
        @(negedge clk);
        check_cnt++;
        if ({tx_en_a, src_ready_a, busy_a} !== 3'b000)
            $display("FAIL reset_mid_ctrl actual=%b required=000", {tx_en_a, src_ready_a, busy_a});
        else
            pass_cnt++;
        check_cnt++;
        if (seq_a !== 8'd0 || pkt_count_a !== 16'd0)
            $display("FAIL reset_mid_counters actual=%0d/%0d required=0/0", seq_a, pkt_count_a);
        else
            pass_cnt++;
        check_cnt++;
        if (exp_a.size() != 0)
            $display("FAIL reset_mid_pending actual=%0d required=0", exp_a.size());
        else
            pass_cnt++;
        exp_a.delete();
        @(posedge clk);
        #1;
        run_stream_a(1, 1'b0, 1'b0, 2, 16'h0200);
    endtask

    // 257 single-word packets back to back; seq wraps 0xFF -> 0x00.
    task automatic test_wrap();
        int          cyc, sent;
        bit          accepted, done;
        logic [15:0] w;
        for (int p = 0; p < 257; p++) begin
            w = (p == 0) ? 16'hFFFF : 16'h0002;
            exp_b.push_back({8'hA5, 8'(p)});
            exp_b.push_back(16'(LEN_B));
            exp_b.push_back(w);
            exp_b.push_back(fold(INIT, w));
        end
        writes_b  = 0;
        sent      = 0;
        done      = 1'b0;
        tx_full_b = 1'b0;
        for (cyc = 0; cyc < 2000 && !done; cyc++) begin
            enable_b    = (cyc < 1026);
            src_valid_b = (sent < 257);
            src_data_b  = (sent == 0) ? 16'hFFFF : 16'h0002;
            @(negedge clk);
            accepted = src_valid_b && src_ready_b;
            done     = (exp_b.size() == 0) && (busy_b === 1'b0);
            @(posedge clk);
            #1;
            if (accepted) sent++;
        end
        enable_b    = 1'b0;
        src_valid_b = 1'b0;
        check_cnt++;
        if (!done)
            $display("FAIL wrap_timeout actual=%0d_pending required=0", exp_b.size());
        else
            pass_cnt++;
        check_cnt++;
        if (pkt_count_b !== 16'd257 || seq_b !== 8'd1)
            $display("FAIL wrap_counters actual=%0d/%0d required=257/1", pkt_count_b, seq_b);
        else
            pass_cnt++;
        check_cnt++;
        if (writes_b != 1028 || last_wr_b - first_wr_b != 1027)
            $display("FAIL wrap_throughput actual=%0d_writes_span_%0d required=1028_span_1027",
                     writes_b, last_wr_b - first_wr_b);
        else
            pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/tx_packet_framer.md
Name: tx_packet_framer

Overview:
- Sits directly upstream of the ft600_mode245 TX port.
- Takes a raw 16-bit word stream from a data source over a valid/ready handshake.
- Wraps it into fixed-length packets of the form header, length, payload, check word.
- Writes those packets into the FT600 TX FIFO using its tx_en/tx_in/tx_full write interface, so the host can detect lost or corrupted words.

Parameters:
- PAYLOAD_LEN, 64, payload words per packet; legal range 1..65535.
- SYNC, 8'hA5, sync byte placed in the header word's upper byte.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  level; while high, the framer starts new packets.
- src_valid  input  1  source word available.
- src_data  input  16  source word.
- src_ready  output  1  framer accepts src_data this cycle.
- tx_en  output  1  write strobe to the TX FIFO; a write occurs at a posedge with tx_en=1.
- tx_data  output  16  word written to the TX FIFO (connects to tx_in).
- tx_full  input  1  TX FIFO full.
- busy  output  1  high whenever state != IDLE.
- pkt_count  output  16  count of completed packets; wraps.
- seq  output  8  sequence number of the current or next packet.

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk.
  - Resets to state IDLE, seq=0, pkt_count=0, checksum=0, word counter=0.
  - src_ready=0, tx_en=0, tx_data=0, busy=0.
- Reset mid-packet abandons the partial packet immediately; no check word is emitted.
- tx_en, src_ready and tx_data are combinational from state, registers, src_valid, src_data and tx_full.
- tx_en is never high while tx_full=1.
- IDLE:
  - tx_en=0, src_ready=0.
  - enable=1 -> HDR on the next clock.
- HDR:
  - tx_data={SYNC,seq}; tx_en=~tx_full.
  - On a write -> LEN. Otherwise hold.
- LEN:
  - tx_data=PAYLOAD_LEN[15:0]; tx_en=~tx_full.
  - On a write -> PAYLOAD, and clear word counter and checksum.
- PAYLOAD:
  - src_ready=~tx_full; tx_en=src_valid & ~tx_full; tx_data=src_data.
  - Each write: fold src_data into checksum and increment word counter.
  - On the write of word PAYLOAD_LEN-1 (counter==PAYLOAD_LEN-1) -> CSUM.
  - src_valid low or tx_full high stalls with no state change. Zero-length gaps are allowed.
- CSUM:
  - tx_data=checksum; tx_en=~tx_full.
  - On a write: seq<=seq+1 (8-bit wrap, 0xFF->0x00); pkt_count<=pkt_count+1 (16-bit wrap).
  - Next state: HDR if enable=1, else IDLE.
- Check word (default): 16-bit modular sum of all payload words, initial 0, carry discarded.
- enable is sampled only in IDLE and at packet end. Deasserting it mid-packet does not truncate the packet.
- Throughput: with tx_full=0 and src_valid=1 continuously, exactly one word is written per clock. A packet occupies PAYLOAD_LEN+3 consecutive cycles, and back-to-back packets have no gap.
- src_ready is 0 outside PAYLOAD; source words are never consumed during header, length or check words.

Optional Feature:
- Macro: FRAMER_CRC16_EN.
- Defined: the check word is CRC-16/CCITT-FALSE over the payload.
  - Polynomial 0x1021, init 0xFFFF, non-reflected, no final XOR.
  - Each 16-bit word is processed MSB first (high byte then low byte), one whole word per clock.
  - The CRC register is reinitialised to 0xFFFF on entry to PAYLOAD.
- Undefined: the modular-sum check word described above; no CRC logic is instantiated.
- Framing, timing and all other behaviour are identical in both builds.

Test Plan:
- Basic packet (PAYLOAD_LEN=4, enable=1, src words 0x0001..0x0004 always valid, tx_full=0):
  - Writes 0xA500, 0x0004, 0x0001, 0x0002, 0x0003, 0x0004, 0x000A on 7 consecutive cycles.
  - Then pkt_count=1, seq=1, and the next header is 0xA501.
- Backpressure: same stimulus with tx_full forced high for 3 cycles during LEN, and again during the 2nd payload word.
  - tx_en=0 and src_ready=0 throughout each stall.
  - Output sequence is unchanged, with no duplicated or dropped words.
- Source gaps: src_valid toggling 1,0,0,1,... -> tx_en follows src_valid; the checksum still equals the sum of the accepted words.
- Wrap-around: PAYLOAD_LEN=1 with payload 0xFFFF, then 0x0002, run 257 packets.
  - First check word is 0xFFFF.
  - The 256th header is 0xA5FF and the 257th header is 0xA500; pkt_count=257.
- Enable drop and reset:
  - enable low after the header write -> the packet completes (all 7 words), then busy=0 and state is IDLE.
  - rst during payload word 2 -> tx_en=0 next cycle, seq=0, pkt_count=0, and the next packet starts with 0xA500.
- FRAMER_CRC16_EN build, PAYLOAD_LEN=4, payload 0x0001..0x0004 -> check word matches a software CRC-16/CCITT-FALSE of bytes 00 01 00 02 00 03 00 04.
